// File: rtl/coax_pkg.sv
// coax_pkg: definitions shared by the 3270 coax transmitter and receiver.
// Holds the transmitter state encoding, frame geometry and the word parity rule.
package coax_pkg;

  localparam int unsigned QUIESCE_BITS = 5;               // "1" bits opening each frame
  localparam int unsigned WORD_W       = 10;              // payload bits per word
  localparam int unsigned FRAME_BITS   = WORD_W + 2;      // sync + payload + parity
  localparam int unsigned CV_BITS      = 3;               // start code violation length
  localparam int unsigned END_BITS     = 3;               // end bit + 1.5-bit mini violation (last bit is half used)

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_QUIESCE,
    S_START_CV,
    S_WORD,
    S_END
  } tx_state_t;

  // Parity bit that makes the count of ones in data+parity even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [WORD_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// coax_tx_bit_timer: per-bit clock counter for the coax transmitter.
// Flags the last clock of the first half-bit, the last clock of the bit,
// and whether the current clock lies in the second half of the bit.
module coax_tx_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_end,
  output logic bit_end,
  output logic second_half
);

  localparam int unsigned CW   = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned HALF = CLOCKS_PER_BIT / 2;

  logic [CW-1:0] cnt;

  // Clock counter within the bit: wraps at CLOCKS_PER_BIT-1, held at zero while clear.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end     = (cnt == CW'(CLOCKS_PER_BIT - 1));
  assign half_end    = (cnt == CW'(HALF - 1));
  assign second_half = (cnt >= CW'(HALF));

endmodule

// File: rtl/coax_tx.sv
// coax_tx: 3270 coax Manchester transmitter.
// One-word holding register feeds a 12-bit frame shifter; frames are
// start sequence, back-to-back words, end sequence.
// Optional feature macro: COAX_TX_DELAY_EN (tx_delay = tx delayed CLOCKS_PER_BIT/4 clocks).
module coax_tx
  import coax_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data,
  input  logic              load,
  input  logic              parity,
  output logic              ready,
  output logic              active,
  output logic              tx,
  output logic              tx_delay
);

  tx_state_t             state, state_next;
  logic [WORD_W-1:0]     hold_data;
  logic                  hold_odd;
  logic                  hold_valid;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            bit_idx;
  logic                  half_end, bit_end, second_half;
  logic                  accept, take_word, restart;

  assign ready  = ~hold_valid;
  assign active = (state != S_IDLE);
  assign accept = load & ready;

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == S_IDLE),
    .half_end   (half_end),
    .bit_end    (bit_end),
    .second_half(second_half)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, line level and word hand-off strobe.
  always_comb begin
    state_next = state;
    take_word  = 1'b0;
    tx         = 1'b0;
    case (state)
      S_IDLE: begin
        // A load in IDLE starts the frame on the very next clock.
        if (hold_valid || accept) state_next = S_START_QUIESCE;
      end
      S_START_QUIESCE: begin
        tx = second_half;
        if (bit_end && bit_idx == 4'(QUIESCE_BITS - 1)) state_next = S_START_CV;
      end
      S_START_CV: begin
        tx = (bit_idx == 4'd0) || (bit_idx == 4'd1 && !second_half);
        if (bit_end && bit_idx == 4'(CV_BITS - 1)) begin
          state_next = S_WORD;
          take_word  = 1'b1;
        end
      end
      S_WORD: begin
        tx = second_half ? shift[FRAME_BITS-1] : ~shift[FRAME_BITS-1];
        if (bit_end && bit_idx == 4'(FRAME_BITS - 1)) begin
          if (hold_valid) begin
            take_word = 1'b1;
          end else begin
            state_next = S_END;
          end
        end
      end
      S_END: begin
        tx = (bit_idx == 4'd0) ? ~second_half : 1'b1;
        if (half_end && bit_idx == 4'(END_BITS - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Back-to-back words stay in S_WORD, so the bit index restarts on every word hand-off too.
  assign restart = (state_next != state) || take_word;

  // Bit index, frame shifter and holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_idx    <= '0;
      shift      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_odd   <= 1'b0;
    end else begin
      if (restart) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 1'b1;
      end

      if (take_word) begin
        shift <= {1'b1, hold_data, parity_bit(hold_data, hold_odd)};
      end else if (state == S_WORD && bit_end) begin
        shift <= {shift[FRAME_BITS-2:0], 1'b0};
      end

      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= data;
        hold_odd   <= parity;
      end else if (take_word) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef COAX_TX_DELAY_EN
  localparam int unsigned DLY = CLOCKS_PER_BIT / 4;
  logic [DLY-1:0] dly;

  // Pre-emphasis copy of the line, DLY clocks late.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dly <= '0;
    end else begin
      dly[0] <= tx;
      for (int unsigned i = 1; i < DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign tx_delay = dly[DLY-1];
`else
  assign tx_delay = 1'b0;
`endif

endmodule

// File: tb/tb_coax_tx.sv
// tb_coax_tx: self-checking bench for coax_tx against a frame-level waveform model.
module tb_coax_tx;

  localparam int CPB = 8;
  localparam int H   = CPB / 2;
  localparam int D   = CPB / 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       load;
  logic       parity;
  logic       ready, active, tx, tx_delay;

  always #5 clk = ~clk;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .load    (load),
    .parity  (parity),
    .ready   (ready),
    .active  (active),
    .tx      (tx),
    .tx_delay(tx_delay)
  );

  int tests = 0;
  int fails = 0;

  logic [9:0] wd[4];
  logic       wp[4];
  logic       exp_tx[$], exp_act[$];
  logic       got_tx[$], got_act[$], got_dly[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pbit(input logic [9:0] d, input logic p);
    int c;
    c = $countones(d) + int'(p);
    return (c % 2) == 1;
  endfunction

  task automatic push(input logic b, input logic a, input int n);
    repeat (n) begin
      exp_tx.push_back(b);
      exp_act.push_back(a);
    end
  endtask

  task automatic man(input logic b);
    push(!b, 1'b1, H);
    push(b, 1'b1, H);
  endtask

  // Expected line for one frame carrying words first..first+n-1.
  task automatic model_frame(input int first, input int n);
    repeat (5) man(1'b1);
    push(1'b1, 1'b1, 3 * H);
    push(1'b0, 1'b1, 3 * H);
    for (int i = first; i < first + n; i++) begin
      man(1'b1);
      for (int j = 9; j >= 0; j--) man(wd[i][j]);
      man(pbit(wd[i], wp[i]));
    end
    man(1'b0);
    push(1'b1, 1'b1, 3 * H);
  endtask

  task automatic drive_word(input int i);
    load   = 1'b1;
    data   = wd[i];
    parity = wp[i];
  endtask

  task automatic run_frame(input string tag, input int nw, input bit junk, input bit late);
    int   next, nerr_tx, nerr_act, nerr_dly, act_cnt, base, nwords;
    logic expd;
    logic [9:0] dec;
    exp_tx.delete(); exp_act.delete();
    got_tx.delete(); got_act.delete(); got_dly.delete();
    if (late) begin
      model_frame(0, 1);
      push(1'b0, 1'b0, 1);
      model_frame(1, 1);
    end else begin
      model_frame(0, nw);
    end
    push(1'b0, 1'b0, 4);

    @(negedge clk);
    drive_word(0);
    next = 1;
    @(posedge clk);
    for (int k = 0; k < exp_tx.size(); k++) begin
      @(negedge clk);
      got_tx.push_back(tx);
      got_act.push_back(active);
      got_dly.push_back(tx_delay);
      load = 1'b0;
      if (!late && next < nw && ready) begin
        drive_word(next);
        next++;
      end else if (late && k == 159) begin
        drive_word(1);
      end else if (junk && !ready) begin
        load   = 1'b1;
        data   = 10'($urandom);
        parity = 1'($urandom);
      end
    end
    load = 1'b0;

    nerr_tx = 0; nerr_act = 0; nerr_dly = 0; act_cnt = 0;
    for (int k = 0; k < exp_tx.size(); k++) begin
      if (got_tx[k] !== exp_tx[k]) nerr_tx++;
      if (got_act[k] !== exp_act[k]) nerr_act++;
`ifdef COAX_TX_DELAY_EN
      expd = (k >= D) ? exp_tx[k-D] : 1'b0;
`else
      expd = 1'b0;
`endif
      if (got_dly[k] !== expd) nerr_dly++;
      if (got_act[k] === 1'b1) act_cnt++;
    end
    check($sformatf("%s.tx_wave_errs", tag), nerr_tx, 0);
    check($sformatf("%s.active_wave_errs", tag), nerr_act, 0);
    check($sformatf("%s.tx_delay_errs", tag), nerr_dly, 0);
    check($sformatf("%s.active_clocks", tag), act_cnt, late ? 360 : 180 + 96 * (nw - 1));
    check($sformatf("%s.end_ready", tag), ready, 1);
    check($sformatf("%s.end_active", tag), active, 0);

    nwords = late ? 2 : nw;
    for (int i = 0; i < nwords; i++) begin
      base = late ? ((i == 0) ? 64 : 181 + 64) : 64 + 96 * i;
      for (int j = 0; j < 10; j++) dec[9-j] = got_tx[base + (j + 1) * CPB + H];
      check($sformatf("%s.w%0d_sync", tag, i), got_tx[base + H], 1);
      check($sformatf("%s.w%0d_data", tag, i), dec, wd[i]);
      check($sformatf("%s.w%0d_parity", tag, i), got_tx[base + 11 * CPB + H], pbit(wd[i], wp[i]));
    end
  endtask

  initial begin
    int  act_seen;
    bit  loaded;
    reset  = 1'b0;
    load   = 1'b0;
    data   = '0;
    parity = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", ready, 1);
    check("rst.active", active, 0);
    check("rst.tx", tx, 0);
    check("rst.tx_delay", tx_delay, 0);
    reset = 1'b1;
    @(negedge clk);

    wd[0] = 10'b0000001010; wp[0] = 1'b1;
    run_frame("odd_0x00a", 1, 1'b0, 1'b0);
    check("odd_0x00a.parity_is_1", pbit(wd[0], wp[0]), 1);

    wd[0] = 10'b1111111111; wp[0] = 1'b0;
    run_frame("even_0x3ff", 1, 1'b0, 1'b0);

    wd[0] = 10'($urandom); wp[0] = 1'($urandom);
    wd[1] = 10'($urandom); wp[1] = 1'($urandom);
    run_frame("two_words_junk", 2, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        wd[i] = 10'($urandom);
        wp[i] = 1'($urandom);
      end
      run_frame($sformatf("rand%0d", r), n, 1'($urandom), 1'b0);
    end

    wd[0] = 10'($urandom); wp[0] = 1'($urandom);
    wd[1] = 10'($urandom); wp[1] = 1'($urandom);
    run_frame("late_load", 2, 1'b0, 1'b1);

    // Reset mid-word with a second word pending in the holding register.
    wd[0] = 10'($urandom); wp[0] = 1'($urandom);
    wd[1] = 10'($urandom); wp[1] = 1'($urandom);
    @(negedge clk);
    drive_word(0);
    @(posedge clk);
    loaded = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == 98) check("midrst.pre_ready", ready, 0);
      if (ready && !loaded) begin
        drive_word(1);
        loaded = 1'b1;
      end
    end
    reset = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    check("midrst.tx", tx, 0);
    check("midrst.active", active, 0);
    check("midrst.ready", ready, 1);
    check("midrst.tx_delay", tx_delay, 0);
    reset = 1'b1;
    act_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (active !== 1'b0) act_seen++;
    end
    check("midrst.stays_idle", act_seen, 0);

    wd[0] = 10'($urandom); wp[0] = 1'($urandom);
    run_frame("after_rst", 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
